// File: rtl/fwd_pkg.sv
// Shared constants and helpers for the EX forwarding / load-use hazard unit.
// A tracked pipeline entry is packed as {rd, wr, load, valid}, with valid in bit 0.
package fwd_pkg;

  // Select value meaning "take the operand from the register file".
  localparam int FWD_SEL_RF = 0;

  // Bit offsets inside a packed stage entry.
  localparam int ENT_VALID = 0;
  localparam int ENT_LOAD  = 1;
  localparam int ENT_WR    = 2;
  localparam int ENT_RD    = 3;

  // Width of one packed stage entry for a given register address width.
  function automatic int ent_w(input int addr_w);
    return addr_w + ENT_RD;
  endfunction

  // Width of one per-source forward select: values 0..depth.
  function automatic int sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Parameter legality: a load must become forwardable before it leaves the chain.
  function automatic bit cfg_legal(input int num_src, input int depth, input int load_lat);
    return (num_src >= 1) && (num_src <= 3) &&
           (depth >= 1) && (depth <= 6) &&
           (load_lat >= 0) && (load_lat < depth);
  endfunction

endpackage

// File: rtl/fwd_src_match.sv
// Priority forward select for one EX source operand.
// Scans the downstream stage vector and picks the youngest eligible producer.
module fwd_src_match
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W = 4,
  parameter int FWD_DEPTH  = 2,
  parameter int LOAD_LAT   = 1
) (
  input  logic [REG_ADDR_W-1:0]                  rs,
  input  logic                                   rs_used,
  input  logic                                   slot_valid,
  input  logic [FWD_DEPTH*ent_w(REG_ADDR_W)-1:0] stages,
  output logic [sel_w(FWD_DEPTH)-1:0]            sel
);

  localparam int EW    = ent_w(REG_ADDR_W);
  localparam int SEL_W = sel_w(FWD_DEPTH);

  logic [EW-1:0]         ent;
  logic [REG_ADDR_W-1:0] ent_rd;

  // Walk oldest to youngest so the youngest matching producer has the last word.
  always_comb begin
    sel    = SEL_W'(FWD_SEL_RF);
    ent    = '0;
    ent_rd = '0;
    for (int d = FWD_DEPTH; d >= 1; d--) begin
      ent    = stages[(d-1)*EW +: EW];
      ent_rd = ent[ENT_RD +: REG_ADDR_W];
      if (slot_valid && rs_used && ent[ENT_VALID] && ent[ENT_WR] &&
          (ent_rd != '0) && (ent_rd == rs) &&
          !(ent[ENT_LOAD] && (d <= LOAD_LAT)))
        sel = SEL_W'(FWD_DEPTH + 1 - d);
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX operand forwarding and load-use stall generation.
// Tracks the ID/EX slot plus FWD_DEPTH downstream stages internally.
// Optional statistics counters are enabled with the FWD_HAZARD_STATS_EN macro.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W = 4,
  parameter int NUM_SRC    = 2,
  parameter int FWD_DEPTH  = 2,
  parameter int LOAD_LAT   = 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0]       id_rs,
  input  logic [NUM_SRC-1:0]                  id_rs_used,
  input  logic [REG_ADDR_W-1:0]               id_rd,
  input  logic                                id_reg_write,
  input  logic                                id_is_load,
  input  logic                                flush,
  input  logic                                hold,
  output logic                                stall,
  output logic [NUM_SRC*sel_w(FWD_DEPTH)-1:0] fwd_sel
`ifdef FWD_HAZARD_STATS_EN
  ,
  output logic [31:0]                         stat_stall_cycles,
  output logic [31:0]                         stat_fwd_events
`endif
);

  localparam int  EW        = ent_w(REG_ADDR_W);
  localparam int  SEL_W     = sel_w(FWD_DEPTH);
  localparam int  CHW       = FWD_DEPTH * EW;
  localparam bit  CFG_LEGAL = cfg_legal(NUM_SRC, FWD_DEPTH, LOAD_LAT);

  if (!CFG_LEGAL) begin : g_cfg_check
    $error("fwd_hazard_unit: illegal NUM_SRC/FWD_DEPTH/LOAD_LAT combination");
  end

  logic [NUM_SRC*REG_ADDR_W-1:0] slot_rs;
  logic [NUM_SRC-1:0]            slot_rs_used;
  logic [REG_ADDR_W-1:0]         slot_rd;
  logic                          slot_wr;
  logic                          slot_load;
  logic                          slot_valid;
  logic [EW-1:0]                 slot_ent;
  logic [CHW-1:0]                chain;       // S[k] at chain[(k-1)*EW +: EW]

  logic                          load_use;
  logic [REG_ADDR_W-1:0]         src_rs;
  logic [EW-1:0]                 ent;

  assign slot_ent = {slot_rd, slot_wr, slot_load, slot_valid};

  // Advance the tracking pipeline unless frozen; stalled/flushed/empty ID becomes a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_rs      <= '0;
      slot_rs_used <= '0;
      slot_rd      <= '0;
      slot_wr      <= 1'b0;
      slot_load    <= 1'b0;
      slot_valid   <= 1'b0;
      chain        <= '0;
    end else if (!hold) begin
      chain <= (chain << EW) | CHW'(slot_ent);
      if (stall || flush || !id_valid) begin
        slot_rs      <= '0;
        slot_rs_used <= '0;
        slot_rd      <= '0;
        slot_wr      <= 1'b0;
        slot_load    <= 1'b0;
        slot_valid   <= 1'b0;
      end else begin
        slot_rs      <= id_rs;
        slot_rs_used <= id_rs_used;
        slot_rd      <= id_rd;
        slot_wr      <= id_reg_write;
        slot_load    <= id_is_load;
        slot_valid   <= 1'b1;
      end
    end
  end

  // Load-use: an ID source names a load that is still too young to forward from.
  always_comb begin
    load_use = 1'b0;
    src_rs   = '0;
    ent      = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_rs = id_rs[i*REG_ADDR_W +: REG_ADDR_W];
      if (id_rs_used[i] && (src_rs != '0)) begin
        if ((LOAD_LAT > 0) && slot_valid && slot_wr && slot_load && (slot_rd == src_rs))
          load_use = 1'b1;
        for (int k = 1; k <= FWD_DEPTH; k++) begin
          ent = chain[(k-1)*EW +: EW];
          if ((k < LOAD_LAT) && ent[ENT_VALID] && ent[ENT_WR] && ent[ENT_LOAD] &&
              (ent[ENT_RD +: REG_ADDR_W] == src_rs))
            load_use = 1'b1;
        end
      end
    end
  end

  // A flush already bubbles the slot, so it overrides the stall request.
  assign stall = id_valid & load_use & ~flush;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_src_match #(
      .REG_ADDR_W (REG_ADDR_W),
      .FWD_DEPTH  (FWD_DEPTH),
      .LOAD_LAT   (LOAD_LAT)
    ) u_match (
      .rs         (slot_rs[i*REG_ADDR_W +: REG_ADDR_W]),
      .rs_used    (slot_rs_used[i]),
      .slot_valid (slot_valid),
      .stages     (chain),
      .sel        (fwd_sel[i*SEL_W +: SEL_W])
    );
  end

`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] fwd_inc;

  // Number of sources currently taking a forwarded operand.
  always_comb begin
    fwd_inc = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (fwd_sel[i*SEL_W +: SEL_W] != '0)
        fwd_inc = fwd_inc + 32'd1;
  end

  // Saturating event counters; a frozen pipeline does not count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_stall_cycles <= '0;
      stat_fwd_events   <= '0;
    end else if (!hold) begin
      if (stall && !flush && (stat_stall_cycles != 32'hFFFF_FFFF))
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
      if (stat_fwd_events > (32'hFFFF_FFFF - fwd_inc))
        stat_fwd_events <= 32'hFFFF_FFFF;
      else
        stat_fwd_events <= stat_fwd_events + fwd_inc;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: default build (instance a) and a
// three-source, deeper, two-cycle-load build (instance b).
module tb_fwd_hazard_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance a: REG_ADDR_W=4, NUM_SRC=2, FWD_DEPTH=2, LOAD_LAT=1
  logic       a_id_valid, a_id_reg_write, a_id_is_load, a_flush, a_hold, a_stall;
  logic [7:0] a_id_rs;
  logic [1:0] a_id_rs_used;
  logic [3:0] a_id_rd;
  logic [3:0] a_fwd_sel;

  // Instance b: REG_ADDR_W=5, NUM_SRC=3, FWD_DEPTH=3, LOAD_LAT=2
  logic        b_id_valid, b_id_reg_write, b_id_is_load, b_flush, b_hold, b_stall;
  logic [14:0] b_id_rs;
  logic [2:0]  b_id_rs_used;
  logic [4:0]  b_id_rd;
  logic [5:0]  b_fwd_sel;

`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] a_stat_stall, a_stat_fwd, b_stat_stall, b_stat_fwd;
`endif

  fwd_hazard_unit #(.REG_ADDR_W(4), .NUM_SRC(2), .FWD_DEPTH(2), .LOAD_LAT(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .id_valid(a_id_valid), .id_rs(a_id_rs),
    .id_rs_used(a_id_rs_used), .id_rd(a_id_rd), .id_reg_write(a_id_reg_write),
    .id_is_load(a_id_is_load), .flush(a_flush), .hold(a_hold),
    .stall(a_stall), .fwd_sel(a_fwd_sel)
`ifdef FWD_HAZARD_STATS_EN
    , .stat_stall_cycles(a_stat_stall), .stat_fwd_events(a_stat_fwd)
`endif
  );

  fwd_hazard_unit #(.REG_ADDR_W(5), .NUM_SRC(3), .FWD_DEPTH(3), .LOAD_LAT(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .id_valid(b_id_valid), .id_rs(b_id_rs),
    .id_rs_used(b_id_rs_used), .id_rd(b_id_rd), .id_reg_write(b_id_reg_write),
    .id_is_load(b_id_is_load), .flush(b_flush), .hold(b_hold),
    .stall(b_stall), .fwd_sel(b_fwd_sel)
`ifdef FWD_HAZARD_STATS_EN
    , .stat_stall_cycles(b_stat_stall), .stat_fwd_events(b_stat_fwd)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  int exp_stall_cnt = 0;
  int exp_fwd_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int nz_sel_a(input logic [3:0] s);
    return int'(s[1:0] != 2'b00) + int'(s[3:2] != 2'b00);
  endfunction

  // One cycle on instance a: drive ID, check mid-cycle, then take the edge.
  task automatic step_a(input string tag, input logic v, input logic [3:0] rs1,
                        input logic [3:0] rs0, input logic [1:0] used,
                        input logic [3:0] rd, input logic wr, input logic ld,
                        input logic fl, input logic hd,
                        input logic exp_stall, input logic [3:0] exp_sel);
    a_id_valid = v; a_id_rs = {rs1, rs0}; a_id_rs_used = used; a_id_rd = rd;
    a_id_reg_write = wr; a_id_is_load = ld; a_flush = fl; a_hold = hd;
    @(negedge clk);
    chk({tag, ".stall"}, 32'(a_stall), 32'(exp_stall));
    chk({tag, ".sel"}, 32'(a_fwd_sel), 32'(exp_sel));
    if (!hd) begin
      exp_stall_cnt += int'(exp_stall);
      exp_fwd_cnt   += nz_sel_a(exp_sel);
    end
    @(posedge clk); #1;
  endtask

  task automatic step_b(input string tag, input logic v, input logic [14:0] rs,
                        input logic [2:0] used, input logic [4:0] rd,
                        input logic wr, input logic ld,
                        input logic exp_stall, input logic [5:0] exp_sel);
    b_id_valid = v; b_id_rs = rs; b_id_rs_used = used; b_id_rd = rd;
    b_id_reg_write = wr; b_id_is_load = ld;
    @(negedge clk);
    chk({tag, ".stall"}, 32'(b_stall), 32'(exp_stall));
    chk({tag, ".sel"}, 32'(b_fwd_sel), 32'(exp_sel));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_id_valid = 0; a_id_rs = '0; a_id_rs_used = '0; a_id_rd = '0;
    a_id_reg_write = 0; a_id_is_load = 0; a_flush = 0; a_hold = 0;
    b_id_valid = 0; b_id_rs = '0; b_id_rs_used = '0; b_id_rd = '0;
    b_id_reg_write = 0; b_id_is_load = 0; b_flush = 0; b_hold = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.a_stall", 32'(a_stall), 32'd0);
    chk("reset.a_sel", 32'(a_fwd_sel), 32'd0);
    chk("reset.b_stall", 32'(b_stall), 32'd0);
    chk("reset.b_sel", 32'(b_fwd_sel), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    //     tag          v rs1 rs0 used  rd wr ld fl hd  stall sel
    // EX/MEM forward
    step_a("add_x3",    1, 0, 0, 2'b00, 3, 1, 0, 0, 0,  0, 4'b0000);
    step_a("use_x3",    1, 0, 3, 2'b01, 0, 0, 0, 0, 0,  0, 4'b0000);
    step_a("exmem",     0, 0, 0, 2'b00, 0, 0, 0, 0, 0,  0, 4'b0010);
    step_a("idle1",     0, 0, 0, 2'b00, 0, 0, 0, 0, 0,  0, 4'b0000);
    // MEM/WB forward with one NOP between
    step_a("add_x6",    1, 0, 0, 2'b00, 6, 1, 0, 0, 0,  0, 4'b0000);
    step_a("nop",       0, 0, 0, 2'b00, 0, 0, 0, 0, 0,  0, 4'b0000);
    step_a("use_x6",    1, 6, 0, 2'b10, 0, 0, 0, 0, 0,  0, 4'b0000);
    step_a("memwb",     0, 0, 0, 2'b00, 0, 0, 0, 0, 0,  0, 4'b0100);
    // x0 destination never forwards
    step_a("add_x0",    1, 0, 0, 2'b00, 0, 1, 0, 0, 0,  0, 4'b0000);
    step_a("use_x0",    1, 0, 0, 2'b01, 0, 0, 0, 0, 0,  0, 4'b0000);
    step_a("x0_nofwd",  0, 0, 0, 2'b00, 0, 0, 0, 0, 0,  0, 4'b0000);
    // same rd in S[1] and S[2]: youngest wins
    step_a("add_x5a",   1, 0, 0, 2'b00, 5, 1, 0, 0, 0,  0, 4'b0000);
    step_a("add_x5b",   1, 0, 0, 2'b00, 5, 1, 0, 0, 0,  0, 4'b0000);
    step_a("use_x5",    1, 5, 5, 2'b11, 0, 0, 0, 0, 0,  0, 4'b0000);
    step_a("youngest",  0, 0, 0, 2'b00, 0, 0, 0, 0, 0,  0, 4'b1010);
    step_a("idle2",     0, 0, 0, 2'b00, 0, 0, 0, 0, 0,  0, 4'b0000);
    // load-use: one stall cycle, bubble, then MEM/WB forward
    step_a("lw_x4",     1, 0, 0, 2'b00, 4, 1, 1, 0, 0,  0, 4'b0000);
    step_a("lu_stall",  1, 0, 4, 2'b01, 0, 0, 0, 0, 0,  1, 4'b0000);
    step_a("lu_bubble", 1, 0, 4, 2'b01, 0, 0, 0, 0, 0,  0, 4'b0000);
    step_a("lu_fwd",    0, 0, 0, 2'b00, 0, 0, 0, 0, 0,  0, 4'b0001);
    // flush masks stall and squashes the entering instruction
    step_a("lw_x7",     1, 0, 0, 2'b00, 7, 1, 1, 0, 0,  0, 4'b0000);
    step_a("fl_mask",   1, 7, 0, 2'b10, 0, 0, 0, 1, 0,  0, 4'b0000);
    step_a("add_x8",    1, 0, 0, 2'b00, 8, 1, 0, 0, 0,  0, 4'b0000);
    step_a("fl_use_x8", 1, 0, 8, 2'b01, 0, 0, 0, 1, 0,  0, 4'b0000);
    step_a("fl_bubble", 0, 0, 0, 2'b00, 0, 0, 0, 0, 0,  0, 4'b0000);
    // hold during a stall: stall and fwd_sel frozen
    step_a("add_x2",    1, 0, 0, 2'b00, 2, 1, 0, 0, 0,  0, 4'b0000);
    step_a("lw_x9",     1, 0, 2, 2'b01, 9, 1, 1, 0, 0,  0, 4'b0000);
    step_a("hold1",     1, 9, 0, 2'b10, 0, 0, 0, 0, 1,  1, 4'b0010);
    step_a("hold2",     1, 9, 0, 2'b10, 0, 0, 0, 0, 1,  1, 4'b0010);
    step_a("hold3",     1, 9, 0, 2'b10, 0, 0, 0, 0, 1,  1, 4'b0010);
    step_a("hold_rel",  1, 9, 0, 2'b10, 0, 0, 0, 0, 0,  1, 4'b0010);
    step_a("hold_bub",  1, 9, 0, 2'b10, 0, 0, 0, 0, 0,  0, 4'b0000);
    step_a("hold_fwd",  0, 0, 0, 2'b00, 0, 0, 0, 0, 0,  0, 4'b0100);
    // reset while stalling with an active forward
    step_a("add_x11",   1, 0, 0, 2'b00, 11, 1, 0, 0, 0, 0, 4'b0000);
    step_a("lw_x10",    1, 0, 11, 2'b01, 10, 1, 1, 0, 0, 0, 4'b0000);

    a_id_valid = 1; a_id_rs = {4'd10, 4'd0}; a_id_rs_used = 2'b10; a_id_rd = 0;
    a_id_reg_write = 0; a_id_is_load = 0; a_flush = 0; a_hold = 0;
    #2;
    chk("pre_rst.stall", 32'(a_stall), 32'd1);
    chk("pre_rst.sel", 32'(a_fwd_sel), 32'h2);
`ifdef FWD_HAZARD_STATS_EN
    chk("stat.stall", a_stat_stall, 32'(exp_stall_cnt));
    chk("stat.fwd", a_stat_fwd, 32'(exp_fwd_cnt));
`endif
    rst_n = 1'b0;
    #1;
    chk("mid_rst.stall", 32'(a_stall), 32'd0);
    chk("mid_rst.sel", 32'(a_fwd_sel), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_stall_cnt = 0;
    exp_fwd_cnt = 0;

    step_a("post_use",  1, 0, 11, 2'b01, 0, 0, 0, 0, 0, 0, 4'b0000);
    step_a("post_rf",   0, 0, 0, 2'b00, 0, 0, 0, 0, 0,  0, 4'b0000);
`ifdef FWD_HAZARD_STATS_EN
    chk("stat.stall_clr", a_stat_stall, 32'(exp_stall_cnt));
    chk("stat.fwd_clr", a_stat_fwd, 32'(exp_fwd_cnt));
`endif

    //     tag          v  rs {rs2,rs1,rs0}      used    rd  wr ld  stall sel
    step_b("b_lw_x20",  1, {5'd0, 5'd0, 5'd0},   3'b000, 20, 1, 1,  0, 6'b000000);
    step_b("b_stall1",  1, {5'd0, 5'd0, 5'd20},  3'b001, 0,  0, 0,  1, 6'b000000);
    step_b("b_stall2",  1, {5'd0, 5'd0, 5'd20},  3'b001, 0,  0, 0,  1, 6'b000000);
    step_b("b_release", 1, {5'd0, 5'd0, 5'd20},  3'b001, 0,  0, 0,  0, 6'b000000);
    step_b("b_ld_fwd",  0, {5'd0, 5'd0, 5'd0},   3'b000, 0,  0, 0,  0, 6'b000001);
    step_b("b_add_x21", 1, {5'd0, 5'd0, 5'd0},   3'b000, 21, 1, 0,  0, 6'b000000);
    step_b("b_add_x22", 1, {5'd0, 5'd0, 5'd0},   3'b000, 22, 1, 0,  0, 6'b000000);
    step_b("b_use3",    1, {5'd22, 5'd21, 5'd21}, 3'b110, 0, 0, 0,  0, 6'b000000);
    step_b("b_multi",   0, {5'd0, 5'd0, 5'd0},   3'b000, 0,  0, 0,  0, 6'b111000);
    step_b("b_idle",    0, {5'd0, 5'd0, 5'd0},   3'b000, 0,  0, 0,  0, 6'b000000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the two-source EX forwarding logic.
- Tracks in-flight destination registers internally through ID/EX and FWD_DEPTH downstream stages; only the ID-stage decode fields enter the block.
- Produces per-source forward selects for the instruction in EX and a load-use stall for the instruction in ID.
- Sits beside the pipeline registers and drives the EX operand muxes and the IF/ID hold / ID/EX bubble controls.

Parameters:
- REG_ADDR_W, 4, register address width; address 0 is hardwired zero and never forwarded.
- NUM_SRC, 2, source operands per instruction (1..3).
- FWD_DEPTH, 2, forwarding stages after EX (1 = EX/MEM, 2 = MEM/WB, ...); range 1..6.
- LOAD_LAT, 1, load result is forwardable only from stage d > LOAD_LAT; range 0..FWD_DEPTH-1.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  NUM_SRC*REG_ADDR_W  ID source addresses; source i occupies bits [i*REG_ADDR_W +: REG_ADDR_W]
- id_rs_used  in  NUM_SRC  source i is actually read
- id_rd  in  REG_ADDR_W  ID destination
- id_reg_write  in  1  ID instruction writes id_rd
- id_is_load  in  1  ID instruction is a load
- flush  in  1  squash the instruction entering EX (branch/exception)
- hold  in  1  global pipeline freeze (memory wait)
- stall  out  1  hold PC and IF/ID; insert a bubble into ID/EX
- fwd_sel  out  NUM_SRC*SEL_W  per-source EX operand select; SEL_W = clog2(FWD_DEPTH+1)

Behaviour:
- State:
  - ID/EX slot: rs, rs_used, rd, wr, load, valid.
  - Shift chain S[1..FWD_DEPTH]: rd, wr, load, valid.
- Reset (async, rst_n=0): every entry valid=0 and wr=0. Resulting outputs: stall=0, fwd_sel=0.
- Clock edge, hold=0:
  - S[k+1] <= S[k]; S[1] <= ID/EX slot.
  - ID/EX slot <= bubble if (stall | flush | !id_valid), else ID fields.
- Clock edge, hold=1: all state retained. Outputs are still evaluated from the current state.
- Forwarding, EX source i:
  - A stage d is a candidate if S[d].valid & S[d].wr & S[d].rd != 0 & S[d].rd == slot.rs[i] & slot.rs_used[i] & slot.valid.
  - Loads at d <= LOAD_LAT are excluded.
  - The smallest d (youngest producer) wins.
  - fwd_sel[i] = FWD_DEPTH+1-d; 0 = register file.
  - For FWD_DEPTH=2 this gives EX/MEM=2'b10 and MEM/WB=2'b01, matching the existing encoding.
  - fwd_sel is a function of registered state only: zero-cycle latency from the edge, no input-to-output path.
- Load-use stall:
  - Stall when id_valid and a used, nonzero id_rs[i] equals the rd of a valid writing load at position p < LOAD_LAT.
  - Positions: p=0 is the ID/EX slot, p=k is S[k].
  - Stall is combinational from ID inputs and state.
  - Multi-cycle loads (LOAD_LAT>1) hold stall for consecutive cycles until the producer reaches position LOAD_LAT.
- flush: forces a bubble into the slot and masks stall (flush wins over a simultaneous stall).
- hold with stall: stall stays asserted; no state change.
- Producers beyond S[FWD_DEPTH] are covered by the register-file write-before-read; no forward.
- Reset mid-stall: stall drops immediately (asynchronous), and all tracking is cleared.

Optional Feature:
- Macro: FWD_HAZARD_STATS_EN.
- Defined:
  - Adds outputs stat_stall_cycles[31:0] and stat_fwd_events[31:0].
  - stat_stall_cycles increments on each clk with stall & !hold & !flush.
  - stat_fwd_events increments per clk with !hold by the number of nonzero fwd_sel fields.
  - Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: the ports and counters are absent; the remaining behaviour is identical.

Decomposition:
- Package fwd_pkg:
  - SEL_W function (clog2).
  - FWD_SEL_RF = 0.
  - Stage-entry field widths and bit offsets.
  - LOAD_LAT / FWD_DEPTH legality check constant.
- Sub-module fwd_src_match: one source address plus the stage vector in, priority-selected fwd_sel out. Instantiated NUM_SRC times.

Test Plan:
- Reset with rst_n=0 mid-stream -> stall=0 and all fwd_sel=0 the same cycle; after release, the first instruction reads the register file.
- ADD x3 then ADD using rs1=x3, defaults -> next cycle fwd_sel[0]=2'b10; with one NOP between, fwd_sel[0]=2'b01; with x0 as destination, 0.
- Same register rd=x5 written at S[1] and S[2] -> fwd_sel=2'b10 (youngest wins).
- LW x4 followed by a user of x4, LOAD_LAT=1 -> stall=1 for exactly 1 cycle, bubble in EX, then fwd_sel=2'b01; with LOAD_LAT=2, FWD_DEPTH=3, stall lasts 2 cycles and then fwd_sel=1.
- Load-use stall coinciding with flush=1 -> stall=0 and the slot becomes a bubble; hold=1 for 3 cycles during a stall -> stall stays 1 and fwd_sel is unchanged.
- NUM_SRC=3, REG_ADDR_W=5, FWD_DEPTH=3 with rs2 and rs3 matching different stages -> independent correct selects. With FWD_HAZARD_STATS_EN, counters equal the scoreboard totals.
